// File: rtl/chi_link_pkg.sv
// Shared types and helpers for the CHI link channel buffer.
// Link-state encoding matches the link_state output port.
package chi_link_pkg;

   typedef enum logic [1:0] {
      LINK_STOP   = 2'd0,
      LINK_RUN    = 2'd1,
      LINK_DRAIN  = 2'd2,
      LINK_RETURN = 2'd3
   } link_state_e;

   localparam int CHI_MAX_CRD    = 15;
   localparam int CHI_FLIT_MAX_W = 512;

   // A flit whose opcode field is all zeros is a link (credit-return) flit.
   function automatic logic is_link_flit(input logic [CHI_FLIT_MAX_W-1:0] flit,
                                         input int lsb,
                                         input int w);
      logic nz;
      nz = 1'b0;
      for (int i = 0; i < CHI_FLIT_MAX_W; i++) begin
         if (i >= lsb && i < lsb + w) begin
            nz = nz | flit[i];
         end
      end
      return !nz;
   endfunction

endpackage

// File: rtl/chi_link_fifo.sv
// Single-clock circular FIFO used as the flit buffer behind the output register.
// Pushing into a full FIFO is a protocol violation caught by an assertion.
module chi_link_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
)(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   cnt,
   output logic                         full,
   output logic                         nempty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full   = (cnt_q == CNT_W'(DEPTH));
   assign nempty = (cnt_q != '0);
   assign cnt    = cnt_q;
   assign dout   = mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && nempty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   fifo_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/chi_link_chan_buf.sv
// One CHI channel buffer: link-state FSM, L-credit counters, flit FIFO and output register.
// Grants are withheld so buffered flits plus outstanding credits never exceed BUF_DEPTH.
module chi_link_chan_buf
   import chi_link_pkg::*;
#(
   parameter int FLIT_WIDTH = 128,
   parameter int OPCODE_LSB = 14,
   parameter int OPCODE_W   = 4,
   parameter int BUF_DEPTH  = 8,
   parameter int MAX_RX_CRD = 15,
   parameter int TX_CRD_MAX = 15,
   parameter int BYPASS     = 1
)(
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           link_req,
   input  logic                           rx_flitpend,
   input  logic                           rx_flitv,
   input  logic [FLIT_WIDTH-1:0]          rx_flit,
   output logic                           rxcrdv,
   output logic                           tx_flitpend,
   output logic                           tx_flitv,
   output logic [FLIT_WIDTH-1:0]          tx_flit,
   input  logic                           txcrdv,
   output logic [1:0]                     link_state,
   output logic [3:0]                     rx_crd_out,
   output logic [3:0]                     tx_crd_cnt,
   output logic [$clog2(BUF_DEPTH+1)-1:0] buf_cnt,
   output logic                           err
);

   localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
   localparam int SUM_W  = ((CNT_W > 4) ? CNT_W : 4) + 1;
   localparam int RX_CAP = (MAX_RX_CRD > CHI_MAX_CRD) ? CHI_MAX_CRD : MAX_RX_CRD;

   link_state_e           state_q, state_d;
   logic [3:0]            rx_crd_q, rx_crd_d;
   logic [3:0]            tx_crd_q, tx_crd_d;
   logic                  err_q, err_d;
   logic                  out_valid_q, out_valid_d;
   logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;

   logic                  fifo_push, fifo_pop, fifo_full, fifo_nempty;
   logic [FLIT_WIDTH-1:0] fifo_dout;
   logic [CNT_W-1:0]      fifo_cnt;
   logic [CNT_W-1:0]      buf_cnt_w;
   logic [SUM_W-1:0]      crd_sum;
   logic                  rx_link, rx_no_crd, rx_data_accept, bypass_ok;
   logic                  grant, send_data, send_link;
   logic                  unused_ok;

   assign unused_ok = ^{rx_flitpend, fifo_full};

   chi_link_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .din    (rx_flit),
      .dout   (fifo_dout),
      .cnt    (fifo_cnt),
      .full   (fifo_full),
      .nempty (fifo_nempty)
   );

   assign buf_cnt_w = fifo_cnt + CNT_W'(out_valid_q);
   assign crd_sum   = SUM_W'(buf_cnt_w) + SUM_W'(rx_crd_q);
   assign rx_link   = is_link_flit(CHI_FLIT_MAX_W'(rx_flit), OPCODE_LSB, OPCODE_W);
   assign rx_no_crd = rx_flitv && (rx_crd_q == 4'd0);
   assign rx_data_accept = rx_flitv && !rx_no_crd && !rx_link && (state_q != LINK_RETURN);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= LINK_STOP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LINK_STOP:   if (link_req) state_d = LINK_RUN;
         LINK_RUN:    if (!link_req) state_d = LINK_DRAIN;
         LINK_DRAIN: begin
            if (link_req) begin
               state_d = LINK_RUN;
            end else if (buf_cnt_w == '0) begin
               state_d = LINK_RETURN;
            end
         end
         LINK_RETURN: if (tx_crd_q == 4'd0 && rx_crd_q == 4'd0) state_d = LINK_STOP;
         default:     state_d = LINK_STOP;
      endcase
   end

   always_comb begin
      grant       = (state_q == LINK_RUN) && (rx_crd_q < 4'(RX_CAP))
                    && (crd_sum < SUM_W'(BUF_DEPTH));
      send_data   = out_valid_q && (tx_crd_q != 4'd0)
                    && (state_q == LINK_RUN || state_q == LINK_DRAIN);
      send_link   = (state_q == LINK_RETURN) && (tx_crd_q != 4'd0);
      rxcrdv      = grant;
      tx_flitv    = send_data || send_link;
      tx_flit     = send_data ? out_flit_q : '0;
      tx_flitpend = ((state_q == LINK_RUN || state_q == LINK_DRAIN)
                     && (out_valid_q || fifo_nempty)) || send_link;
   end

   // Credit accounting; a flit with no credit outstanding is dropped and flagged.
   always_comb begin
      rx_crd_d = rx_crd_q;
      tx_crd_d = tx_crd_q;
      err_d    = err_q;
      if (rx_no_crd) begin
         err_d    = 1'b1;
         rx_crd_d = rx_crd_q + {3'b000, grant};
      end else begin
         rx_crd_d = rx_crd_q + {3'b000, grant} - {3'b000, rx_flitv};
      end
      if (rx_flitv && !rx_no_crd && !rx_link && state_q == LINK_RETURN) begin
         err_d = 1'b1;
      end
      case ({txcrdv, tx_flitv})
         2'b10: begin
            if (tx_crd_q == 4'(TX_CRD_MAX)) begin
               err_d = 1'b1;
            end else begin
               tx_crd_d = tx_crd_q + 4'd1;
            end
         end
         2'b01:   tx_crd_d = tx_crd_q - 4'd1;
         default: tx_crd_d = tx_crd_q;
      endcase
   end

   // The output register refills on the same cycle it sends, so flits stream back-to-back.
   always_comb begin
      fifo_pop    = fifo_nempty && (send_data || !out_valid_q);
      bypass_ok   = (BYPASS != 0) && !fifo_nempty && (send_data || !out_valid_q);
      fifo_push   = rx_data_accept && !bypass_ok;
      out_valid_d = out_valid_q;
      out_flit_d  = out_flit_q;
      if (fifo_pop) begin
         out_valid_d = 1'b1;
         out_flit_d  = fifo_dout;
      end else if (rx_data_accept && bypass_ok) begin
         out_valid_d = 1'b1;
         out_flit_d  = rx_flit;
      end else if (send_data) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_crd_q    <= '0;
         tx_crd_q    <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_flit_q  <= '0;
      end else begin
         rx_crd_q    <= rx_crd_d;
         tx_crd_q    <= tx_crd_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_flit_q  <= out_flit_d;
      end
   end

   assign link_state = state_q;
   assign rx_crd_out = rx_crd_q;
   assign tx_crd_cnt = tx_crd_q;
   assign buf_cnt    = buf_cnt_w;
   assign err        = err_q;

endmodule

// File: tb/tb_chi_link_chan_buf.sv
// Directed bench for chi_link_chan_buf: a vector table for link-up, streaming and
// link-flit handling, then hand-written drain/return, error and reset sequences.
module tb_chi_link_chan_buf;

   localparam int FW = 128;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          link_req = 1'b0;
   logic          rx_flitpend = 1'b0;
   logic          rx_flitv = 1'b0;
   logic [FW-1:0] rx_flit = '0;
   logic          txcrdv = 1'b0;
   logic          rxcrdv, tx_flitpend, tx_flitv, err;
   logic [FW-1:0] tx_flit;
   logic [1:0]    link_state;
   logic [3:0]    rx_crd_out, tx_crd_cnt, buf_cnt;

   int n_compared   = 0;
   int n_mismatched = 0;

   typedef struct {
      logic       rst, lreq, rxv;
      logic [7:0] tag;
      logic [3:0] op;
      logic       txc;
      logic       e_rxcrdv, e_txv;
      logic [7:0] e_tag;
      logic [3:0] e_op;
      logic [1:0] e_st;
      logic [3:0] e_rxc, e_txc, e_buf;
      logic       e_err, e_pend;
   } vec_t;

   vec_t tbl[$];

   always #5 clock = ~clock;

   chi_link_chan_buf dut (
      .clock       (clock),
      .reset       (reset),
      .link_req    (link_req),
      .rx_flitpend (rx_flitpend),
      .rx_flitv    (rx_flitv),
      .rx_flit     (rx_flit),
      .rxcrdv      (rxcrdv),
      .tx_flitpend (tx_flitpend),
      .tx_flitv    (tx_flitv),
      .tx_flit     (tx_flit),
      .txcrdv      (txcrdv),
      .link_state  (link_state),
      .rx_crd_out  (rx_crd_out),
      .tx_crd_cnt  (tx_crd_cnt),
      .buf_cnt     (buf_cnt),
      .err         (err)
   );

   function automatic logic [FW-1:0] mk_flit(input logic [7:0] tag, input logic [3:0] op);
      logic [FW-1:0] f;
      f          = '0;
      f[7:0]     = tag;
      f[17:14]   = op;
      f[127:120] = ~tag;
      return f;
   endfunction

   function automatic vec_t mkv(input logic rst, lreq, rxv, input logic [7:0] tag,
                                input logic [3:0] op, input logic txc,
                                input logic e_rxcrdv, e_txv, input logic [7:0] e_tag,
                                input logic [3:0] e_op, input logic [1:0] e_st,
                                input logic [3:0] e_rxc, e_txc, e_buf, input logic e_pend);
      vec_t v;
      v.rst = rst; v.lreq = lreq; v.rxv = rxv; v.tag = tag; v.op = op; v.txc = txc;
      v.e_rxcrdv = e_rxcrdv; v.e_txv = e_txv; v.e_tag = e_tag; v.e_op = e_op;
      v.e_st = e_st; v.e_rxc = e_rxc; v.e_txc = e_txc; v.e_buf = e_buf;
      v.e_err = 1'b0; v.e_pend = e_pend;
      return v;
   endfunction

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and sample the outputs 1ns after the edge.
   task automatic applyStimulus(input logic rst, input logic lreq, input logic rxv,
                                input logic [FW-1:0] flit, input logic txc);
      reset    = rst;
      link_req = lreq;
      rx_flitv = rxv;
      rx_flit  = flit;
      txcrdv   = txc;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic e_rxcrdv, input logic e_txv,
                              input logic [FW-1:0] e_flit, input logic [1:0] e_st,
                              input logic [3:0] e_rxc, input logic [3:0] e_txc,
                              input logic [3:0] e_buf, input logic e_err, input logic e_pend);
      chk({tag, ".rxcrdv"},      FW'(rxcrdv),      FW'(e_rxcrdv));
      chk({tag, ".tx_flitv"},    FW'(tx_flitv),    FW'(e_txv));
      chk({tag, ".tx_flit"},     tx_flit,          e_flit);
      chk({tag, ".link_state"},  FW'(link_state),  FW'(e_st));
      chk({tag, ".rx_crd_out"},  FW'(rx_crd_out),  FW'(e_rxc));
      chk({tag, ".tx_crd_cnt"},  FW'(tx_crd_cnt),  FW'(e_txc));
      chk({tag, ".buf_cnt"},     FW'(buf_cnt),     FW'(e_buf));
      chk({tag, ".err"},         FW'(err),         FW'(e_err));
      chk({tag, ".tx_flitpend"}, FW'(tx_flitpend), FW'(e_pend));
   endtask

   initial begin
      logic [FW-1:0] lnk;
      lnk = mk_flit(8'h55, 4'd0);

      // rst lreq rxv tag op txc | rxcrdv txv etag eop st rxc txc buf pend
      tbl.push_back(mkv(1,0,0,8'h00,0,0, 0,0,8'h00,0,0,0,0,0,0));
      tbl.push_back(mkv(0,1,0,8'h00,0,0, 1,0,8'h00,0,1,0,0,0,0));
      for (int k = 2; k <= 8; k++)
         tbl.push_back(mkv(0,1,0,8'h00,0,0, 1,0,8'h00,0,1,4'(k-1),0,0,0));
      tbl.push_back(mkv(0,1,0,8'h00,0,0, 0,0,8'h00,0,1,8,0,0,0));
      tbl.push_back(mkv(0,1,0,8'h00,0,0, 0,0,8'h00,0,1,8,0,0,0));
      tbl.push_back(mkv(0,1,0,8'h00,0,1, 0,0,8'h00,0,1,8,1,0,0));
      tbl.push_back(mkv(0,1,0,8'h00,0,1, 0,0,8'h00,0,1,8,2,0,0));
      tbl.push_back(mkv(0,1,1,8'hA1,4,0, 0,1,8'hA1,4,1,7,2,1,1));
      tbl.push_back(mkv(0,1,1,8'hA2,4,0, 1,1,8'hA2,4,1,6,1,1,1));
      tbl.push_back(mkv(0,1,1,8'hA3,4,0, 1,0,8'h00,0,1,6,0,1,1));
      tbl.push_back(mkv(0,1,0,8'h00,0,0, 0,0,8'h00,0,1,7,0,1,1));
      tbl.push_back(mkv(0,1,0,8'h00,0,1, 0,1,8'hA3,4,1,7,1,1,1));
      tbl.push_back(mkv(0,1,0,8'h00,0,0, 1,0,8'h00,0,1,7,0,0,0));
      tbl.push_back(mkv(0,1,0,8'h00,0,0, 0,0,8'h00,0,1,8,0,0,0));
      tbl.push_back(mkv(0,1,1,8'h55,0,0, 1,0,8'h00,0,1,7,0,0,0));
      tbl.push_back(mkv(0,1,0,8'h00,0,0, 0,0,8'h00,0,1,8,0,0,0));

      $display("[TB] vector table: %0d rows", tbl.size());
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].rst, tbl[i].lreq, tbl[i].rxv, mk_flit(tbl[i].tag, tbl[i].op),
                       tbl[i].txc);
         checkOutput($sformatf("vec%0d", i), tbl[i].e_rxcrdv, tbl[i].e_txv,
                     tbl[i].e_txv ? mk_flit(tbl[i].e_tag, tbl[i].e_op) : '0,
                     tbl[i].e_st, tbl[i].e_rxc, tbl[i].e_txc, tbl[i].e_buf,
                     tbl[i].e_err, tbl[i].e_pend);
      end

      // Drain with two buffered flits (second goes through the FIFO), then return credits.
      $display("[TB] drain/return sequence");
      applyStimulus(0, 1, 1, mk_flit(8'hB1, 2), 0);
      checkOutput("drn.b1", 0, 0, '0, 1, 7, 0, 1, 0, 1);
      applyStimulus(0, 1, 1, mk_flit(8'hB2, 2), 0);
      checkOutput("drn.b2", 0, 0, '0, 1, 6, 0, 2, 0, 1);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("drn.enter", 0, 0, '0, 2, 6, 0, 2, 0, 1);
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("drn.d1", 0, 1, mk_flit(8'hB1, 2), 2, 6, 1, 2, 0, 1);
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("drn.d2", 0, 1, mk_flit(8'hB2, 2), 2, 6, 1, 1, 0, 1);
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("drn.d3", 0, 0, '0, 2, 6, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("ret.r0", 0, 1, '0, 3, 6, 2, 0, 0, 1);
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("ret.r1", 0, 1, '0, 3, 6, 2, 0, 0, 1);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("ret.r2", 0, 1, '0, 3, 6, 1, 0, 0, 1);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("ret.r3", 0, 0, '0, 3, 6, 0, 0, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(0, 1, 1, lnk, 0);
         checkOutput($sformatf("ret.lnk%0d", i), 0, 0, '0, 3, 4'(6 - i), 0, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("ret.stop", 0, 0, '0, 0, 0, 0, 0, 0, 0);

      // TX credit saturation, then RX flit without credit; err is sticky until reset.
      $display("[TB] error sequence");
      applyStimulus(1, 0, 0, '0, 0);
      for (int i = 1; i <= 15; i++) begin
         applyStimulus(0, 0, 0, '0, 1);
         chk($sformatf("sat%0d.tx_crd_cnt", i), FW'(tx_crd_cnt), FW'(i));
         chk($sformatf("sat%0d.err", i), FW'(err), '0);
      end
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("sat16", 0, 0, '0, 0, 0, 15, 0, 1, 0);
      applyStimulus(1, 0, 0, '0, 0);
      checkOutput("err.rst", 0, 0, '0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, mk_flit(8'hC1, 3), 0);
      checkOutput("err.nocrd", 0, 0, '0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, '0, 0);
      checkOutput("err.sticky", 1, 0, '0, 1, 0, 0, 0, 1, 0);

      // Reset mid-RUN with four flits buffered and credit/flit inputs active.
      $display("[TB] mid-run reset sequence");
      applyStimulus(1, 0, 0, '0, 0);
      applyStimulus(0, 1, 0, '0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, '0, 0);
      chk("mrr.pre.rx_crd_out", FW'(rx_crd_out), FW'(8));
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, mk_flit(8'(8'hD0 + i), 5), 0);
      checkOutput("mrr.pre", 0, 0, '0, 1, 4, 0, 4, 0, 1);
      applyStimulus(1, 1, 1, mk_flit(8'hDF, 5), 1);
      checkOutput("mrr.rst", 0, 0, '0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("mrr.idle", 0, 0, '0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
